branch_resolve_unit: RTL and testbench

Parametrised branch evaluation and prediction unit for the 16-bit core, the successor to the combinational jump calculator. It predicts branch direction at fetch from a table of 2-bit saturating counters, resolves conditional and unconditional branches against the SZCV flags in the execute stage, and reports taken/mispredict/redirect one cycle later. It also keeps a saturating mispredict counter for performance monitoring.

---
 rtl/branch_resolve_unit.sv | 113 +++++++++++
 tb/tb_branch_resolve_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch prediction (2-bit counter table) and execute-stage branch resolution
// for the 16-bit core, with a saturating mispredict counter.
module branch_resolve_unit #(
    parameter int unsigned PC_W      = 12,
    parameter int unsigned DISP_W    = 8,
    parameter int unsigned BHT_IDX_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_W-1:0]      f_pc,
    input  logic [15:0]          f_instr,
    output logic                 pred_taken,
    output logic [PC_W-1:0]      pred_dest,
    input  logic                 r_valid,
    input  logic [PC_W-1:0]      r_pc,
    input  logic [15:0]          r_instr,
    input  logic [3:0]           r_szcv,
    input  logic                 r_pred,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 redirect,
    output logic [PC_W-1:0]      redirect_pc,
    output logic [CNT_W-1:0]     mis_cnt
);

    localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;
    localparam logic [4:0]  OP_B      = 5'b10100;
    localparam logic [4:0]  OP_BCOND  = 5'b10111;

    // Branch target: pc + sign-extended displacement + 1, wrapping in PC_W bits.
    function automatic logic [PC_W-1:0] calc_target(input logic [PC_W-1:0] pc,
                                                    input logic [15:0]     instr);
        logic [PC_W-1:0] disp_ext;
        disp_ext = PC_W'($signed(instr[DISP_W-1:0]));
        return pc + disp_ext + PC_W'(1);
    endfunction

    // Flag condition evaluation; undefined condition codes are never taken.
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] szcv);
        logic s, z, v;
        s = szcv[3];
        z = szcv[2];
        v = szcv[0];
        case (cond)
            3'b000:  return z;
            3'b001:  return s ^ v;
            3'b010:  return z | (s ^ v);
            3'b011:  return ~z;
            default: return 1'b0;
        endcase
    endfunction

    logic [BHT_DEPTH-1:0][1:0] bht;

    logic                 f_is_b;
    logic                 f_is_bcond;
    logic                 r_is_b;
    logic                 r_is_bcond;
    logic                 r_taken;
    logic                 r_mis;
    logic [PC_W-1:0]      r_next_pc;
    logic [BHT_IDX_W-1:0] r_idx;
    logic [1:0]           ctr_cur;
    logic [1:0]           ctr_next;
    logic                 unused_bits;

    assign unused_bits = ^{f_instr[10:8], r_szcv[1]};

    // Fetch-side prediction; reads the table as it stands, no update bypass.
    always_comb begin
        f_is_b     = (f_instr[15:11] == OP_B);
        f_is_bcond = (f_instr[15:11] == OP_BCOND);
        pred_taken = f_is_b | (f_is_bcond & bht[f_pc[BHT_IDX_W-1:0]][1]);
        pred_dest  = calc_target(f_pc, f_instr);
    end

    // Execute-side outcome and next counter value.
    always_comb begin
        r_is_b     = (r_instr[15:11] == OP_B);
        r_is_bcond = (r_instr[15:11] == OP_BCOND);
        r_taken    = r_is_b | (r_is_bcond & cond_met(r_instr[10:8], r_szcv));
        r_mis      = (r_taken != r_pred);
        r_next_pc  = r_taken ? calc_target(r_pc, r_instr) : (r_pc + PC_W'(1));
        r_idx      = r_pc[BHT_IDX_W-1:0];
        ctr_cur    = bht[r_idx];
        ctr_next   = ctr_cur;
        if (r_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            mis_cnt     <= '0;
            bht         <= {BHT_DEPTH{2'b01}};
        end else begin
            res_valid <= r_valid;
            res_taken <= r_valid & r_taken;
            redirect  <= r_valid & r_mis;
            if (r_valid) redirect_pc <= r_next_pc;
            if (r_valid && r_mis && (mis_cnt != {CNT_W{1'b1}})) mis_cnt <= mis_cnt + CNT_W'(1);
            if (r_valid && r_is_bcond) bht[r_idx] <= ctr_next;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model pushes expected
// results at drive time; they are popped and compared after each clock edge.
module tb_branch_resolve_unit;

    localparam int unsigned PC_W      = 12;
    localparam int unsigned DISP_W    = 8;
    localparam int unsigned BHT_IDX_W = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int          MIS_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PC_W-1:0]   f_pc = '0;
    logic [15:0]       f_instr = '0;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_dest;
    logic              r_valid = 1'b0;
    logic [PC_W-1:0]   r_pc = '0;
    logic [15:0]       r_instr = '0;
    logic [3:0]        r_szcv = '0;
    logic              r_pred = 1'b0;
    logic              res_valid;
    logic              res_taken;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  mis_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .PC_W(PC_W), .DISP_W(DISP_W), .BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .f_pc(f_pc), .f_instr(f_instr),
        .pred_taken(pred_taken), .pred_dest(pred_dest),
        .r_valid(r_valid), .r_pc(r_pc), .r_instr(r_instr), .r_szcv(r_szcv), .r_pred(r_pred),
        .res_valid(res_valid), .res_taken(res_taken), .redirect(redirect),
        .redirect_pc(redirect_pc), .mis_cnt(mis_cnt)
    );

    typedef struct packed {
        logic             v;
        logic             t;
        logic             rd;
        logic [PC_W-1:0]  pc;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int              m_bht[16];
    logic [PC_W-1:0] m_rpc;
    int              m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [PC_W-1:0] m_target(input logic [PC_W-1:0] pc, input logic [15:0] instr);
        logic [31:0] t;
        t = int'(pc) + int'($signed(instr[7:0])) + 1;
        return t[PC_W-1:0];
    endfunction

    function automatic logic m_taken(input logic [15:0] instr, input logic [3:0] f);
        logic s, z, v;
        s = f[3]; z = f[2]; v = f[0];
        if (instr[15:11] == 5'h14) return 1'b1;
        if (instr[15:11] != 5'h17) return 1'b0;
        case (instr[10:8])
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_pred();
        logic pt;
        if (f_instr[15:11] == 5'h14)      pt = 1'b1;
        else if (f_instr[15:11] == 5'h17) pt = (m_bht[f_pc[3:0]] >= 2);
        else                              pt = 1'b0;
        check("pred_taken", 32'(pred_taken), 32'(pt));
        check("pred_dest", 32'(pred_dest), 32'(m_target(f_pc, f_instr)));
    endtask

    task automatic compare();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("res_valid", 32'(res_valid), 32'(e.v));
        check("res_taken", 32'(res_taken), 32'(e.t));
        check("redirect", 32'(redirect), 32'(e.rd));
        check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
        check("mis_cnt", 32'(mis_cnt), 32'(e.mc));
    endtask

    // One clock: drive a resolve (or idle), check the prediction before the edge,
    // then compare the registered result after it.
    task automatic cycle(input logic v, input logic [PC_W-1:0] pc, input logic [15:0] instr,
                         input logic [3:0] f, input logic pred);
        exp_t e;
        logic t;
        int   idx;
        @(negedge clk);
        rst_n = 1'b1; r_valid = v; r_pc = pc; r_instr = instr; r_szcv = f; r_pred = pred;
        #1 check_pred();
        t    = m_taken(instr, f);
        e.v  = v;
        e.t  = v & t;
        e.rd = v & (t != pred);
        if (v) m_rpc = t ? m_target(pc, instr) : PC_W'(pc + 1'b1);
        if (v && (t != pred) && m_mis < MIS_MAX) m_mis++;
        if (v && instr[15:11] == 5'h17) begin
            idx = int'(pc[3:0]);
            if (t) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else   m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        e.pc = m_rpc;
        e.mc = CNT_W'(m_mis);
        sb.push_back(e);
        @(posedge clk);
        #1 compare();
    endtask

    task automatic do_reset(input logic v);
        @(negedge clk);
        rst_n = 1'b0; r_valid = v; r_pc = 12'h007; r_instr = 16'hB800; r_szcv = 4'b0100; r_pred = 1'b0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_rpc = '0;
        m_mis = 0;
        sb.push_back('0);
        @(posedge clk);
        #1 compare();
    endtask

    initial begin
        f_pc = 12'h005; f_instr = 16'hB800;
        do_reset(1'b0);
        do_reset(1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0);

        // BE taken twice at index 5, predicted not taken each time
        cycle(1'b1, 12'h005, 16'hB810, 4'b0100, 1'b0);
        cycle(1'b1, 12'h005, 16'hB810, 4'b0100, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0);

        // Wrap-around target and fall-through
        cycle(1'b1, 12'h000, 16'hA0FE, 4'b0000, 1'b1);
        cycle(1'b1, 12'hFFF, 16'hBB00, 4'b0100, 1'b0);
        f_pc = 12'hFFF; f_instr = 16'hA0FE;
        cycle(1'b0, '0, '0, '0, 1'b0);

        // Condition matrix
        cycle(1'b1, 12'h020, 16'hB904, 4'b1000, 1'b0);
        cycle(1'b1, 12'h021, 16'hB904, 4'b1001, 1'b1);
        cycle(1'b1, 12'h022, 16'hBAF0, 4'b0100, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'h02A, 16'hBD07, 4'(i), 1'b0);

        // Same-index lookup and update in one cycle, then saturation
        f_pc = 12'h009; f_instr = 16'hB800;
        for (int i = 0; i < 5; i++) cycle(1'b1, 12'h009, 16'hB800, 4'b0100, 1'b1);
        cycle(1'b1, 12'h009, 16'hB800, 4'b0000, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b0);

        // Non-branch resolves
        cycle(1'b1, 12'h030, 16'h1234, 4'b1111, 1'b1);
        cycle(1'b1, 12'h031, 16'h1234, 4'b1111, 1'b0);

        // Mispredict counter saturation
        for (int i = 0; i < 20; i++) cycle(1'b1, 12'h040, 16'hA005, 4'b0000, 1'b0);

        // Random back-to-back stream
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            case ($urandom_range(0, 3))
                0:       ins = {5'b10100, 11'($urandom)};
                1, 2:    ins = {5'b10111, 11'($urandom)};
                default: ins = 16'($urandom);
            endcase
            f_pc    = 12'($urandom);
            f_instr = ($urandom_range(0, 1) == 1) ? {5'b10111, 11'($urandom)} : 16'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 7)), ins,
                  4'($urandom), 1'($urandom));
        end

        // Reset with a concurrent resolve, then sweep the table
        cycle(1'b1, 12'h007, 16'hB800, 4'b0100, 1'b0);
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            f_pc = 12'(i); f_instr = 16'hB800;
            cycle(1'b0, '0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
